// File: rtl/tt_count_chk_pkg.sv
// Shared types and pin map for the counter-stream sequence checker.
package tt_count_chk_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   localparam int VALID_BIT  = 0;
   localparam int CLR_BIT    = 1;
   localparam int LOCKED_BIT = 4;
   localparam int ERR_BIT    = 5;
   localparam int SAT_BIT    = 6;
   localparam int WRAP_BIT   = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit saturating up-counter; clear beats increment.
module sat_counter8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] cnt,
   output logic       sat
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'h00;
      end else if (clr) begin
         cnt <= 8'h00;
      end else if (inc && (cnt != 8'hFF)) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign sat = (cnt == 8'hFF);

endmodule

// File: rtl/tt_um_count_checker.sv
// Receiver for the free-running counter tile: checks +1 sequence,
// tracks lock and keeps a saturating error count.
module tt_um_count_checker
   import tt_count_chk_pkg::*;
#(
   parameter int LOCK_N = 4,
   parameter int LOSS_N = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   localparam logic [3:0] LOCK_V = 4'(LOCK_N);
   localparam logic [3:0] LOSS_V = 4'(LOSS_N);

   state_t     state, state_n;
   logic [7:0] expected, exp_n;
   logic [3:0] match_cnt, match_n;
   logic [3:0] miss_cnt, miss_n;
   logic       err_q, err_n;
   logic       wrap_q, wrap_n;
   logic       inc;
   logic       sat;
   logic [7:0] err_cnt;

   logic valid, clr, hit;
   logic unused_ok;

   assign valid     = uio_in[VALID_BIT];
   assign clr       = uio_in[CLR_BIT];
   assign hit       = (ui_in == expected);
   assign unused_ok = &{1'b0, ena, uio_in[7:2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         expected  <= 8'h00;
         match_cnt <= 4'd0;
         miss_cnt  <= 4'd0;
         err_q     <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state     <= state_n;
         expected  <= exp_n;
         match_cnt <= match_n;
         miss_cnt  <= miss_n;
         err_q     <= err_n;
         wrap_q    <= wrap_n;
      end
   end

   always_comb begin
      state_n = state;
      exp_n   = expected;
      match_n = match_cnt;
      miss_n  = miss_cnt;
      err_n   = 1'b0;
      wrap_n  = 1'b0;
      inc     = 1'b0;
      if (valid) begin
         unique case (state)
            S_IDLE: begin
               exp_n   = ui_in + 8'd1;
               match_n = 4'd0;
               state_n = S_ACQUIRE;
            end
            S_ACQUIRE: begin
               if (hit) begin
                  exp_n   = expected + 8'd1;
                  match_n = match_cnt + 4'd1;
                  if (match_n == LOCK_V) begin
                     state_n = S_LOCKED;
                     miss_n  = 4'd0;
                  end
               end else begin
                  exp_n   = ui_in + 8'd1;
                  match_n = 4'd0;
               end
            end
            S_LOCKED: begin
               if (hit) begin
                  exp_n  = expected + 8'd1;
                  miss_n = 4'd0;
                  wrap_n = (ui_in == 8'h00);
               end else begin
                  // resync on the observed value so one glitch costs one error
                  err_n  = 1'b1;
                  inc    = 1'b1;
                  exp_n  = ui_in + 8'd1;
                  miss_n = miss_cnt + 4'd1;
                  if (miss_n == LOSS_V) begin
                     state_n = S_ACQUIRE;
                     match_n = 4'd0;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   sat_counter8 u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc),
      .cnt   (err_cnt),
      .sat   (sat)
   );

   assign uo_out  = err_cnt;
   assign uio_oe  = UIO_OE_VAL;
   assign uio_out = {wrap_q, sat, err_q, (state == S_LOCKED), 4'b0000};

endmodule

// File: doc/tt_um_count_checker.md
# tt_um_count_checker

Sequence checker for the 8-bit free-running counter stream: samples an 8-bit count on `ui_in`, verifies each sample equals the previous sample plus one (mod 256), and reports lock status and a saturating error count. It is the receiving end of the counter tile, so the two designs can be chained pin-to-pin on the TinyTapeout carrier for board-level self-test.

## Interface

Parameters:
- `LOCK_N`, default 4: consecutive correct samples required to enter LOCKED (range 1–15).
- `LOSS_N`, default 3: consecutive mismatches in LOCKED that force a return to ACQUIRE (range 1–15).

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: always 1 when the design is powered; ignored.
- `ui_in`  in  8: observed count value.
- `uio_in`  in  8: bit 0 = `valid`, sample strobe. Bit 1 = `clr`, synchronous error-count clear. Bits 7:2 are unused.
- `uio_out`  out  8: bit 4 = `locked`, bit 5 = `err`, bit 6 = `err_sat`, bit 7 = `wrap`. Bits 3:0 are 0.
- `uio_oe`  out  8: constant 8'hF0.
- `uo_out`  out  8: error count, saturating.

## Operation

- States are IDLE, ACQUIRE and LOCKED. Internal registers are `expected[7:0]`, `match_cnt[3:0]`, `miss_cnt[3:0]`, `err_cnt[7:0]`.
- A sample occurs on any rising edge with `valid`=1. With `valid`=0, state and counters hold, and the `err` and `wrap` pulses drop to 0.
- IDLE, on a sample: `expected` ← `ui_in`+1, `match_cnt` ← 0, go to ACQUIRE.
- ACQUIRE, on a sample:
  - Match (`ui_in`==`expected`): `match_cnt`+1 and `expected`+1. When the incremented `match_cnt` reaches `LOCK_N`, go to LOCKED and set `miss_cnt` ← 0.
  - Mismatch: `expected` ← `ui_in`+1 and `match_cnt` ← 0. No error is counted.
- LOCKED, on a sample:
  - Match: `expected`+1 and `miss_cnt` ← 0. `wrap` pulses if `ui_in`==8'h00.
  - Mismatch: `err` pulses, `err_cnt`+1 saturating at 8'hFF, `expected` ← `ui_in`+1 (resync), `miss_cnt`+1.
  - When the incremented `miss_cnt` reaches `LOSS_N`, go to ACQUIRE with `match_cnt` ← 0.
- All `+1` arithmetic is 8-bit modulo 256, so 8'hFF → 8'h00 counts as a match.
- `err_sat` = (`err_cnt`==8'hFF). It is registered, and stays set until `clr` or reset.
- `clr`=1 sets `err_cnt` ← 0 on that edge. It has priority over a same-edge increment. The `err` pulse still asserts for that mismatch. FSM state is unaffected.
- `locked` = (state==LOCKED).
- Reset (asserted at any time, including mid-lock) forces IDLE asynchronously: all registers 0, and all outputs 0 except `uio_oe`.

## Timing

- All outputs are registered and change only on the rising edge of `clk` (or asynchronously on reset). There is no combinational path from inputs to outputs.
- `err` and `wrap` are one-cycle pulses, visible in the cycle after the sampling edge. They are high for exactly one cycle per event and are re-evaluated on every edge.
- Lock latency with `valid` held at 1 and a clean stream: the first sample is at edge E0. `locked` rises after edge E0+`LOCK_N` (E4 by default).
- Loss latency: `locked` falls after the `LOSS_N`-th consecutive mismatching sample.
- `valid` gaps do not break lock. `expected` advances per sample, not per cycle.
- Exactly one sample is accepted per valid edge. There is no backpressure.

## Structure

- Package `tt_count_chk_pkg` holds:
  - `state_t` enum `{S_IDLE, S_ACQUIRE, S_LOCKED}` in 2 bits;
  - the `uio` bit-index constants (`VALID_BIT`=0, `CLR_BIT`=1, `LOCKED_BIT`=4, `ERR_BIT`=5, `SAT_BIT`=6, `WRAP_BIT`=7);
  - `UIO_OE_VAL`=8'hF0.
- One sub-module is natural: `sat_counter8`, an 8-bit saturating up-counter with synchronous clear (clear has priority) and a `sat` flag. It is instantiated for `err_cnt`. The FSM, `expected`, `match_cnt` and `miss_cnt` stay in the top level.

## Test plan

- **Clean lock:** after reset, `valid`=1 and `ui_in` = 0,1,2,… each cycle. `locked`=1 from the cycle after the 5th sample. `uo_out` stays 0 and `err` never pulses.
- **Wrap:** while locked, the stream 8'hFE, 8'hFF, 8'h00, 8'h01. No error is counted, and `wrap` is high for exactly one cycle after the 8'h00 sample.
- **Single glitch:**
  - While locked, the stream 10,11,99,100,101. `err` pulses once after the 99 sample and `uo_out`=1.
  - `locked` stays 1, and 100 and 101 are accepted as matches (resync).
- **Loss of lock:** with `LOSS_N`=3, three consecutive non-sequential samples (5,50,200) while locked.
  - `uo_out`=3, `locked`=0 after the third sample.
  - It re-locks after 4 subsequent clean samples.
- **Saturation and clear:**
  - 260 mismatches while locked, with `LOSS_N`=15, alternating matches to hold lock. `uo_out`=8'hFF and `err_sat`=1.
  - `clr` on a mismatch edge: `uo_out`=0, `err` pulses, `err_sat`=0 next cycle.
- **Gaps and mid-op reset:**
  - `valid` toggled 1/0 with the stream advancing only on valid cycles: lock is achieved and there are no errors.
  - `rst_n` pulled low mid-lock, asynchronously, between edges: `uo_out`=0, `uio_out`=0 and `locked`=0 immediately. It returns to IDLE, and `uio_oe` stays 8'hF0.
